// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory arbiter: shares one single-port memory between CPU word accesses
// and video read bursts, with bounded CPU latency during bursts and video fairness in idle.
module fb_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int LW      = 5,
    parameter int CPU_RUN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic [LW-1:0] vid_len,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // state  | meaning
    // IDLE   | no burst open; CPU ops, single-beat and zero-length bursts complete here
    // VBURST | burst beats 1..len-1 issuing, CPU slotted in after VID_RUN beats
    typedef enum logic {
        IDLE,
        VBURST
    } state_t;

    localparam int         CRW     = $clog2(CPU_RUN + 1);
    localparam logic [2:0] VID_RUN = 3'd4;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] remain_q, remain_d;
    logic [CRW-1:0] crun_q, crun_d;
    logic [2:0]    vrun_q, vrun_d;
    logic          cpu_rv_q, cpu_rv_d;
    logic          vid_rv_q, vid_rv_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            remain_q <= '0;
            crun_q   <= '0;
            vrun_q   <= '0;
            cpu_rv_q <= 1'b0;
            vid_rv_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            remain_q <= remain_d;
            crun_q   <= crun_d;
            vrun_q   <= vrun_d;
            cpu_rv_q <= cpu_rv_d;
            vid_rv_q <= vid_rv_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        remain_d  = remain_q;
        crun_d    = crun_q;
        vrun_d    = vrun_q;
        cpu_rv_d  = 1'b0;
        vid_rv_d  = 1'b0;
        done_d    = 1'b0;
        cpu_gnt   = 1'b0;
        vid_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // everything combinational stays quiet while reset is held
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (cpu_req && !(vid_req && crun_q == CRW'(CPU_RUN))) begin
                        cpu_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        cpu_rv_d  = !cpu_we;
                    end else if (vid_req) begin
                        vid_gnt = 1'b1;
                        base_d  = vid_addr;
                        len_d   = vid_len;
                        if (vid_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            mem_en   = 1'b1;
                            mem_addr = vid_addr;
                            vid_rv_d = 1'b1;
                            idx_d    = LW'(1);
                            vrun_d   = 3'd1;
                            if (vid_len == LW'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                remain_d = vid_len - LW'(1);
                                state_d  = VBURST;
                            end
                        end
                    end
                end
                VBURST: begin
                    if (cpu_req && vrun_q == VID_RUN) begin
                        cpu_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        cpu_rv_d  = !cpu_we;
                        vrun_d    = 3'd0;
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = base_q + AW'(idx_q);
                        vid_rv_d = 1'b1;
                        idx_d    = idx_q + LW'(1);
                        remain_d = remain_q - LW'(1);
                        if (vrun_q != VID_RUN)
                            vrun_d = vrun_q + 3'd1;
                        if (remain_q == LW'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // run of CPU wins only counts while video is actually waiting
            if (!vid_req || vid_gnt)
                crun_d = '0;
            else if (cpu_gnt && crun_q != CRW'(CPU_RUN))
                crun_d = crun_q + CRW'(1);
        end
    end

    assign cpu_rvalid = cpu_rv_q & reset;
    assign vid_rvalid = vid_rv_q & reset;
    assign vid_done   = done_q & reset;
    assign busy       = (state_q == VBURST) & reset;
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: per-cycle vector table plus burst/CPU interleave
// and mid-burst reset sequences against a behavioural memory.
module tb_fb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [4:0]  vid_len;
    logic        vid_gnt, vid_rvalid, vid_done;
    logic [31:0] vid_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    fb_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_len(vid_len),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .vid_done(vid_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural memory: unwritten words read back as A5A5_<addr>
    logic [31:0] mem [logic [15:0]];

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'hA5A5, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem_rd(mem_addr);
        end
    end

    typedef struct {
        logic        r;
        logic        creq, cwe;
        logic [15:0] ca;
        logic [31:0] cwd;
        logic        vreq;
        logic [15:0] va;
        logic [4:0]  vl;
        logic        cg, vg, en, we;
        logic [15:0] ma;
        logic [31:0] mwd;
        logic        bsy, crv, vrv, dn;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, creq, cwe, input logic [15:0] ca, input logic [31:0] cwd,
        input logic vreq, input logic [15:0] va, input logic [4:0] vl,
        input logic cg, vg, en, we, input logic [15:0] ma, input logic [31:0] mwd,
        input logic bsy, crv, vrv, dn, input logic [31:0] rd);
        vec_t v;
        v.r = r; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
        v.vreq = vreq; v.va = va; v.vl = vl;
        v.cg = cg; v.vg = vg; v.en = en; v.we = we; v.ma = ma; v.mwd = mwd;
        v.bsy = bsy; v.crv = crv; v.vrv = vrv; v.dn = dn; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0; vid_len = '0;
    endtask

    vec_t tv [26];

    initial begin
        idle_inputs();
        reset = 1'b0;
        mem[16'h0010] = 32'hDEADBEEF;

        //            r cq we ca       cwd          vq va       vl  | cg vg en we ma       mwd          b crv vrv dn rd
        tv[0]  = mk(0, 1, 0, 16'h0010, 32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 0, 0, 32'h0);
        tv[1]  = mk(0, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 0, 0, 32'h0);
        tv[2]  = mk(1, 1, 0, 16'h0010, 32'h0,       0, 16'h0,    0,  1, 0, 1, 0, 16'h0010, 32'h0,       0, 0, 0, 0, 32'h0);
        tv[3]  = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 1, 0, 0, 32'hDEADBEEF);
        tv[4]  = mk(1, 1, 1, 16'h0020, 32'h12345678,0, 16'h0,    0,  1, 0, 1, 1, 16'h0020, 32'h12345678,0, 0, 0, 0, 32'h0);
        tv[5]  = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 0, 0, 32'h0);
        tv[6]  = mk(1, 1, 0, 16'h0020, 32'h0,       0, 16'h0,    0,  1, 0, 1, 0, 16'h0020, 32'h0,       0, 0, 0, 0, 32'h0);
        tv[7]  = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 1, 0, 0, 32'h12345678);
        tv[8]  = mk(1, 0, 0, 16'h0,    32'h0,       1, 16'h0100, 1,  0, 1, 1, 0, 16'h0100, 32'h0,       0, 0, 0, 0, 32'h0);
        tv[9]  = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 1, 1, 32'hA5A50100);
        tv[10] = mk(1, 0, 0, 16'h0,    32'h0,       1, 16'h0200, 0,  0, 1, 0, 0, 16'h0,    32'h0,       0, 0, 0, 0, 32'h0);
        tv[11] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 0, 1, 32'h0);
        tv[12] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 0, 0, 32'h0);
        tv[13] = mk(1, 0, 0, 16'h0,    32'h0,       1, 16'hFFFE, 4,  0, 1, 1, 0, 16'hFFFE, 32'h0,       0, 0, 0, 0, 32'h0);
        tv[14] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 1, 0, 16'hFFFF, 32'h0,       1, 0, 1, 0, 32'hA5A5FFFE);
        tv[15] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 1, 0, 16'h0000, 32'h0,       1, 0, 1, 0, 32'hA5A5FFFF);
        tv[16] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 1, 0, 16'h0001, 32'h0,       1, 0, 1, 0, 32'hA5A50000);
        tv[17] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 1, 1, 32'hA5A50001);
        tv[18] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 0, 0, 0, 32'h0);
        tv[19] = mk(1, 1, 0, 16'h0010, 32'h0,       1, 16'h0300, 1,  1, 0, 1, 0, 16'h0010, 32'h0,       0, 0, 0, 0, 32'h0);
        tv[20] = mk(1, 1, 0, 16'h0010, 32'h0,       1, 16'h0300, 1,  1, 0, 1, 0, 16'h0010, 32'h0,       0, 1, 0, 0, 32'hDEADBEEF);
        tv[21] = mk(1, 1, 0, 16'h0010, 32'h0,       1, 16'h0300, 1,  1, 0, 1, 0, 16'h0010, 32'h0,       0, 1, 0, 0, 32'hDEADBEEF);
        tv[22] = mk(1, 1, 0, 16'h0010, 32'h0,       1, 16'h0300, 1,  1, 0, 1, 0, 16'h0010, 32'h0,       0, 1, 0, 0, 32'hDEADBEEF);
        tv[23] = mk(1, 1, 0, 16'h0010, 32'h0,       1, 16'h0300, 1,  0, 1, 1, 0, 16'h0300, 32'h0,       0, 1, 0, 0, 32'hDEADBEEF);
        tv[24] = mk(1, 1, 0, 16'h0010, 32'h0,       0, 16'h0,    0,  1, 0, 1, 0, 16'h0010, 32'h0,       0, 0, 1, 1, 32'hA5A50300);
        tv[25] = mk(1, 0, 0, 16'h0,    32'h0,       0, 16'h0,    0,  0, 0, 0, 0, 16'h0,    32'h0,       0, 1, 0, 0, 32'hDEADBEEF);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            reset = tv[i].r; cpu_req = tv[i].creq; cpu_we = tv[i].cwe;
            cpu_addr = tv[i].ca; cpu_wdata = tv[i].cwd;
            vid_req = tv[i].vreq; vid_addr = tv[i].va; vid_len = tv[i].vl;
            #2;
            chk($sformatf("vec%0d outputs", i),
                64'({cpu_gnt, vid_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                     busy, cpu_rvalid, vid_rvalid, vid_done}),
                64'({tv[i].cg, tv[i].vg, tv[i].en, tv[i].we, tv[i].ma, tv[i].mwd,
                     tv[i].bsy, tv[i].crv, tv[i].vrv, tv[i].dn}));
            if (tv[i].crv) chk($sformatf("vec%0d cpu_rdata", i), 64'(cpu_rdata), 64'(tv[i].rd));
            if (tv[i].vrv) chk($sformatf("vec%0d vid_rdata", i), 64'(vid_rdata), 64'(tv[i].rd));
        end

        // CPU request arriving mid-burst (16 beats from 0x1000)
        begin
            int gnt_cyc = -1, crv_cyc = -1, beats = 0, rv = 0, dn = 0;
            int addr_err = 0, data_err = 0, done_err = 0;
            logic cg_seen = 1'b0;
            logic [31:0] cpu_rd_seen = '0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                idle_inputs();
                vid_req = (c == 0); vid_addr = 16'h1000; vid_len = 5'd16;
                cpu_req = (c >= 2) && !cg_seen; cpu_addr = 16'h0040;
                #2;
                if (cpu_gnt) begin
                    cg_seen = 1'b1; gnt_cyc = c;
                    if (mem_addr !== 16'h0040) addr_err++;
                end else if (mem_en) begin
                    if (mem_addr !== 16'h1000 + 16'(beats)) addr_err++;
                    beats++;
                end
                if (cpu_rvalid) begin crv_cyc = c; cpu_rd_seen = cpu_rdata; end
                if (vid_rvalid) begin
                    if (vid_rdata !== {16'hA5A5, 16'h1000 + 16'(rv)}) data_err++;
                    rv++;
                end
                if (vid_done) begin
                    dn++;
                    if (!vid_rvalid || rv != 16) done_err++;
                end
            end
            n_total++;
            if (gnt_cyc < 2 || gnt_cyc > 6)
                $display("FAIL burst cpu_gnt cycle: got %0d expected 2..6", gnt_cyc);
            else n_pass++;
            chk("burst cpu rvalid cycle", 64'(crv_cyc), 64'(gnt_cyc + 1));
            chk("burst cpu rdata", 64'(cpu_rd_seen), 64'h00000000A5A50040);
            chk("burst address order errors", 64'(addr_err), 64'd0);
            chk("burst beats issued", 64'(beats), 64'd16);
            chk("burst rvalid count", 64'(rv), 64'd16);
            chk("burst data errors", 64'(data_err), 64'd0);
            chk("burst done count", 64'(dn), 64'd1);
            chk("burst done alignment", 64'(done_err), 64'd0);
        end

        // reset asserted during beat 3 of an 8-beat burst
        begin
            int rv_pre = 0, rv_post = 0, dn_post = 0, busy_post = 0, en_post = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                idle_inputs();
                vid_req = (c == 0); vid_addr = 16'h2000; vid_len = 5'd8;
                reset = (c != 3);
                #2;
                if (c < 3 && vid_rvalid) rv_pre++;
                if (c == 3)
                    chk("reset strobes", 64'({cpu_gnt, vid_gnt, mem_en, mem_we, busy,
                                              cpu_rvalid, vid_rvalid, vid_done}), 64'd0);
                if (c >= 4) begin
                    if (vid_rvalid) rv_post++;
                    if (vid_done)   dn_post++;
                    if (busy)       busy_post++;
                    if (mem_en)     en_post++;
                end
            end
            chk("pre-reset rvalids", 64'(rv_pre), 64'd2);
            chk("post-reset rvalids", 64'(rv_post), 64'd0);
            chk("post-reset done", 64'(dn_post), 64'd0);
            chk("post-reset busy", 64'(busy_post), 64'd0);
            chk("post-reset mem_en", 64'(en_post), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 16, word-address width; DW, 32, data width; LW, 5, burst-length width; CPU_RUN, 4, max consecutive CPU grants while video waits.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request; held with we/addr/wdata until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  pulse: CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- vid_req  in  1  video burst request; held with addr/len until vid_gnt
- vid_addr  in  AW  burst start word address
- vid_len  in  LW  burst length in words
- vid_gnt  out  1  pulse: burst accepted
- vid_rvalid  out  1  video beat data valid
- vid_rdata  out  DW  video beat data
- vid_done  out  1  pulse: burst complete
- mem_en, mem_we  out  1 each  memory strobe / write enable
- mem_addr  out  AW;  mem_wdata  out  DW  memory address / write data
- mem_rdata  in  DW  read data, valid the cycle after mem_en & !mem_we
- busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE and VBURST; at most one memory op SHALL issue per cycle.
REQ-004 CPU grant SHALL be combinational in the issuing cycle: cpu_gnt=1, mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-005 For a CPU read, cpu_rvalid SHALL be 1 exactly one cycle after cpu_gnt, with cpu_rdata=mem_rdata; CPU writes SHALL produce no rvalid.
REQ-006 In IDLE with only cpu_req: grant CPU, remain IDLE.
REQ-007 In IDLE with vid_req granted: vid_gnt=1; latch vid_addr and vid_len; issue beat 0 the same cycle; enter VBURST if vid_len>1.
REQ-008 In IDLE with both requests: CPU SHALL win unless the consecutive-CPU-grant counter equals CPU_RUN.
REQ-009 The consecutive-CPU-grant counter SHALL increment per cpu_gnt while vid_req=1, SHALL clear on vid_gnt, and SHALL clear when vid_req=0.
REQ-010 In VBURST, one beat SHALL issue per cycle: mem_en=1, mem_we=0, address = start+beat index, wrapping modulo 2^AW.
REQ-011 During VBURST, a pending cpu_req SHALL be served after at most 4 consecutive video beats: that cycle issues the CPU op and the burst pauses one cycle, then resumes at the next address.
REQ-012 vid_rvalid SHALL be 1 one cycle after each video beat, with vid_rdata=mem_rdata.
REQ-013 vid_done SHALL pulse coincident with the last beat's vid_rvalid; the FSM SHALL return to IDLE in the cycle after the last beat issues.
REQ-014 vid_len=0 SHALL be accepted (vid_gnt pulse) with no beats issued, and vid_done SHALL pulse the following cycle.
REQ-015 When idle, the mem_* outputs SHALL be 0; cpu_rdata and vid_rdata are don't-care when their rvalid is 0.

Reset
REQ-016 While reset=0 at a clock edge: FSM→IDLE; counters, latched address and length→0.
REQ-017 While reset=0: all strobes (gnt, rvalid, done, mem_en, mem_we, busy) SHALL be 0.
REQ-018 Reset mid-burst SHALL abort the burst: no rvalid or done SHALL appear for beats issued before reset, including the cycle immediately after reset release.

Verification
REQ-019 CPU read: cpu_req=1, we=0, addr=0x0010, memory holds 0xDEADBEEF → cpu_gnt in cycle 0, cpu_rvalid and cpu_rdata=0xDEADBEEF in cycle 1.
REQ-020 Video burst: vid_addr=0xFFFE, vid_len=4 → beat addresses FFFE, FFFF, 0000, 0001 on consecutive cycles; 4 rvalids; vid_done on the 4th rvalid.
REQ-021 CPU during burst: vid_len=16, cpu_req held from burst cycle 2 → cpu_gnt by cycle 6 at the latest; video resumes at the next address; 16 rvalids total.
REQ-022 Video fairness: cpu_req and vid_req held continuously → vid_gnt after exactly 4 cpu_gnts.
REQ-023 vid_len=0 → vid_gnt, no mem_en, vid_done next cycle; reset=0 during beat 3 of 8 → no further rvalid or done, busy=0.
